// File: rtl/sfx_pkg.sv
// Shared types for the sound-effect scheduler: effect encoding, one-hot triggers, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sfx_pkg;

  // Numeric order doubles as priority: WIN > EXPLODE > DROP > NONE.
  typedef enum logic [1:0] {
    SFX_NONE    = 2'd0,
    SFX_DROP    = 2'd1,
    SFX_EXPLODE = 2'd2,
    SFX_WIN     = 2'd3
  } sfx_t;

  localparam logic [3:0] CTRL_NONE    = 4'b0000;
  localparam logic [3:0] CTRL_DROP    = 4'b0001;
  localparam logic [3:0] CTRL_EXPLODE = 4'b0010;
  localparam logic [3:0] CTRL_WIN     = 4'b0100;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_PLAYING = 2'd2
  } state_t;

  function automatic logic [3:0] sfx_onehot(input sfx_t s);
    case (s)
      SFX_DROP:    sfx_onehot = CTRL_DROP;
      SFX_EXPLODE: sfx_onehot = CTRL_EXPLODE;
      SFX_WIN:     sfx_onehot = CTRL_WIN;
      default:     sfx_onehot = CTRL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sfx_pending_ctr.sv
// Per-type 2-bit saturating pending-event counter with a one-cycle overflow strobe.
// Latency: count reflects inc/dec one cycle later; ovf is combinational from this cycle's inputs.
// Backpressure: none; an increment at full count is dropped and flagged on ovf.
// Ports: clk, reset_n (async, active-low), inc (event), dec (consume), cnt (pending count), ovf (lost event).
module sfx_pending_ctr (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] cnt,
  output logic       ovf
);

  // Simultaneous inc and dec cancel, so a full counter only overflows on a lone inc.
  always_comb ovf = inc && !dec && (cnt == 2'd3);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 2'd0;
    end else if (inc && !dec && (cnt != 2'd3)) begin
      cnt <= cnt + 2'd1;
    end else if (dec && !inc && (cnt != 2'd0)) begin
      cnt <= cnt - 2'd1;
    end
  end

endmodule

// File: rtl/sfx_scheduler.sv
// Queues one-shot sound-effect events and drives a one-strobe trigger into the effects player.
// Latency: event at t -> pending at t+1 -> control valid at t+2; control drops the cycle after the consuming strobe.
// Backpressure: up to 3 events queued per type; further events are dropped and set sticky ovf.
// Ports: clk, reset_n (async, active-low), sfx_strobe (player sample request), ev_drop/ev_explode/ev_win
//        (event pulses), control (registered one-hot trigger), busy, cur_sfx (0 none..3 win), ovf (sticky).
module sfx_scheduler
  import sfx_pkg::*;
#(
  parameter int DROP_LEN    = 1882,
  parameter int EXPLODE_LEN = 29536,
  parameter int WIN_LEN     = 35200,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sfx_strobe,
  input  logic       ev_drop,
  input  logic       ev_explode,
  input  logic       ev_win,
  output logic [3:0] control,
  output logic       busy,
  output logic [1:0] cur_sfx,
  output logic       ovf
);

  state_t           state_q, state_d;
  sfx_t             cur_q, cur_d;
  sfx_t             sel;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] clip_len;
  logic [3:0]       control_d;
  logic             consume;
  logic [1:0]       pend_drop, pend_expl, pend_win;
  logic             ovf_drop, ovf_expl, ovf_win;
  logic             ovf_q;

  sfx_pending_ctr u_pend_drop (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (ev_drop),
    .dec     (consume && (cur_q == SFX_DROP)),
    .cnt     (pend_drop),
    .ovf     (ovf_drop)
  );

  sfx_pending_ctr u_pend_expl (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (ev_explode),
    .dec     (consume && (cur_q == SFX_EXPLODE)),
    .cnt     (pend_expl),
    .ovf     (ovf_expl)
  );

  sfx_pending_ctr u_pend_win (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (ev_win),
    .dec     (consume && (cur_q == SFX_WIN)),
    .cnt     (pend_win),
    .ovf     (ovf_win)
  );

  // Highest-priority type with anything pending.
  always_comb begin
    sel = SFX_NONE;
    if (pend_win != 2'd0) begin
      sel = SFX_WIN;
    end else if (pend_expl != 2'd0) begin
      sel = SFX_EXPLODE;
    end else if (pend_drop != 2'd0) begin
      sel = SFX_DROP;
    end
  end

  always_comb begin
    case (cur_q)
      SFX_DROP:    clip_len = CNT_W'(DROP_LEN);
      SFX_EXPLODE: clip_len = CNT_W'(EXPLODE_LEN);
      SFX_WIN:     clip_len = CNT_W'(WIN_LEN);
      default:     clip_len = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    consume = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Strobes are ignored here, so a strobe in the cycle that moves us
        // into ISSUE cannot consume a trigger the player never saw.
        if (sel != SFX_NONE) begin
          state_d = ST_ISSUE;
          cur_d   = sel;
        end
      end
      ST_ISSUE: begin
        // The strobe samples the trigger already on control, so it takes
        // precedence over a late retarget in the same cycle.
        if (sfx_strobe) begin
          consume = 1'b1;
          rem_d   = clip_len;
          state_d = ST_PLAYING;
        end else if (sel > cur_q) begin
          cur_d = sel;
        end
      end
      ST_PLAYING: begin
        // Preemption outranks clip end when both land in one cycle.
        if (sel > cur_q) begin
          state_d = ST_ISSUE;
          cur_d   = sel;
          rem_d   = '0;
        end else if (sfx_strobe) begin
          if (rem_q <= CNT_W'(1)) begin
            state_d = ST_IDLE;
            cur_d   = SFX_NONE;
            rem_d   = '0;
          end else begin
            rem_d = rem_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cur_d   = SFX_NONE;
        rem_d   = '0;
      end
    endcase
    // control is registered from the next state so it lines up with ISSUE entry.
    control_d = (state_d == ST_ISSUE) ? sfx_onehot(cur_d) : CTRL_NONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cur_q   <= SFX_NONE;
      rem_q   <= '0;
      control <= CTRL_NONE;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      control <= control_d;
      ovf_q   <= ovf_q | ovf_drop | ovf_expl | ovf_win;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign cur_sfx = cur_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Directed bench for sfx_scheduler with short clip lengths and a strobe every 5 cycles.
// Inputs change just after the falling edge; outputs are sampled on the falling edge.
module tb_sfx_scheduler;

  logic       clk;
  logic       reset_n;
  logic       sfx_strobe;
  logic       ev_drop;
  logic       ev_explode;
  logic       ev_win;
  logic [3:0] control;
  logic       busy;
  logic [1:0] cur_sfx;
  logic       ovf;

  int n_cmp;
  int n_err;

  sfx_scheduler #(
    .DROP_LEN    (4),
    .EXPLODE_LEN (6),
    .WIN_LEN     (8),
    .CNT_W       (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sfx_strobe (sfx_strobe),
    .ev_drop    (ev_drop),
    .ev_explode (ev_explode),
    .ev_win     (ev_win),
    .control    (control),
    .busy       (busy),
    .cur_sfx    (cur_sfx),
    .ovf        (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse(input logic d, input logic e, input logic w);
    ev_drop = d; ev_explode = e; ev_win = w;
    step();
    ev_drop = 1'b0; ev_explode = 1'b0; ev_win = 1'b0;
  endtask

  // Four quiet cycles then one strobe cycle; seen is what the player samples.
  task automatic do_strobe(output logic [3:0] seen);
    repeat (4) step();
    seen = control;
    sfx_strobe = 1'b1;
    step();
    sfx_strobe = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; sfx_strobe = 1'b0; ev_drop = 1'b0; ev_explode = 1'b0; ev_win = 1'b0;
    step(); step();
    n_cmp++; if (control !== 4'b0000) begin n_err++; $display("FAIL reset_control got %b want 0000", control); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (cur_sfx !== 2'd0) begin n_err++; $display("FAIL reset_cur got %0d want 0", cur_sfx); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single_drop();
    logic [3:0] seen;
    pulse(1'b1, 1'b0, 1'b0);
    n_cmp++; if (control !== 4'b0000) begin n_err++; $display("FAIL drop_t1_control got %b want 0000", control); end
    step();
    n_cmp++; if (control !== 4'b0001) begin n_err++; $display("FAIL drop_t2_control got %b want 0001", control); end
    n_cmp++; if (cur_sfx !== 2'd1) begin n_err++; $display("FAIL drop_t2_cur got %0d want 1", cur_sfx); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL drop_t2_busy got %b want 1", busy); end
    do_strobe(seen);
    n_cmp++; if (seen !== 4'b0001) begin n_err++; $display("FAIL drop_seen got %b want 0001", seen); end
    n_cmp++; if (control !== 4'b0000) begin n_err++; $display("FAIL drop_after_strobe got %b want 0000", control); end
    for (int i = 1; i <= 4; i++) begin
      do_strobe(seen);
      n_cmp++; if (seen !== 4'b0000) begin n_err++; $display("FAIL drop_play_seen[%0d] got %b want 0000", i, seen); end
      n_cmp++; if (busy !== (i < 4)) begin n_err++; $display("FAIL drop_play_busy[%0d] got %b want %b", i, busy, (i < 4)); end
    end
    n_cmp++; if (cur_sfx !== 2'd0) begin n_err++; $display("FAIL drop_end_cur got %0d want 0", cur_sfx); end
  endtask

  task automatic test_simultaneous();
    logic [3:0] seen;
    pulse(1'b1, 1'b1, 1'b0);
    step();
    n_cmp++; if (control !== 4'b0010) begin n_err++; $display("FAIL simul_first got %b want 0010", control); end
    do_strobe(seen);
    n_cmp++; if (seen !== 4'b0010) begin n_err++; $display("FAIL simul_first_seen got %b want 0010", seen); end
    for (int i = 1; i <= 6; i++) begin
      do_strobe(seen);
      n_cmp++; if (seen !== 4'b0000) begin n_err++; $display("FAIL simul_expl_seen[%0d] got %b want 0000", i, seen); end
    end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL simul_gap_busy got %b want 0", busy); end
    step();
    n_cmp++; if (control !== 4'b0001) begin n_err++; $display("FAIL simul_second got %b want 0001", control); end
    n_cmp++; if (cur_sfx !== 2'd1) begin n_err++; $display("FAIL simul_second_cur got %0d want 1", cur_sfx); end
    do_strobe(seen);
    n_cmp++; if (seen !== 4'b0001) begin n_err++; $display("FAIL simul_second_seen got %b want 0001", seen); end
    repeat (4) do_strobe(seen);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL simul_end_busy got %b want 0", busy); end
  endtask

  task automatic test_issue_strobe_edge();
    logic [3:0] seen;
    pulse(1'b1, 1'b0, 1'b0);
    sfx_strobe = 1'b1;
    step();
    sfx_strobe = 1'b0;
    n_cmp++; if (control !== 4'b0001) begin n_err++; $display("FAIL edge_entry got %b want 0001", control); end
    step();
    n_cmp++; if (control !== 4'b0001) begin n_err++; $display("FAIL edge_hold got %b want 0001", control); end
    do_strobe(seen);
    n_cmp++; if (control !== 4'b0000) begin n_err++; $display("FAIL edge_consumed got %b want 0000", control); end
    for (int i = 1; i <= 4; i++) begin
      do_strobe(seen);
      n_cmp++; if (busy !== (i < 4)) begin n_err++; $display("FAIL edge_play_busy[%0d] got %b want %b", i, busy, (i < 4)); end
    end
  endtask

  task automatic test_preempt();
    logic [3:0] seen;
    pulse(1'b0, 1'b1, 1'b0);
    step();
    n_cmp++; if (control !== 4'b0010) begin n_err++; $display("FAIL preempt_expl got %b want 0010", control); end
    do_strobe(seen);
    repeat (2) do_strobe(seen);
    pulse(1'b0, 1'b0, 1'b1);
    n_cmp++; if (control !== 4'b0000) begin n_err++; $display("FAIL preempt_pending got %b want 0000", control); end
    step();
    n_cmp++; if (control !== 4'b0100) begin n_err++; $display("FAIL preempt_issue got %b want 0100", control); end
    n_cmp++; if (cur_sfx !== 2'd3) begin n_err++; $display("FAIL preempt_cur got %0d want 3", cur_sfx); end
    do_strobe(seen);
    n_cmp++; if (seen !== 4'b0100) begin n_err++; $display("FAIL preempt_seen got %b want 0100", seen); end
    for (int i = 1; i <= 8; i++) begin
      do_strobe(seen);
      n_cmp++; if (busy !== (i < 8)) begin n_err++; $display("FAIL preempt_win_busy[%0d] got %b want %b", i, busy, (i < 8)); end
    end
    repeat (6) step();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL preempt_no_resume_busy got %b want 0", busy); end
    n_cmp++; if (control !== 4'b0000) begin n_err++; $display("FAIL preempt_no_resume_ctrl got %b want 0000", control); end
  endtask

  task automatic test_saturation();
    logic [3:0] seen;
    pulse(1'b0, 1'b0, 1'b1);
    step();
    n_cmp++; if (control !== 4'b0100) begin n_err++; $display("FAIL sat_win_issue got %b want 0100", control); end
    do_strobe(seen);
    for (int i = 0; i < 8; i++) begin
      if (i < 5) begin
        pulse(1'b1, 1'b0, 1'b0);
        n_cmp++; if (ovf !== (i >= 3)) begin n_err++; $display("FAIL sat_ovf[%0d] got %b want %b", i, ovf, (i >= 3)); end
      end
      do_strobe(seen);
      n_cmp++; if (seen !== 4'b0000) begin n_err++; $display("FAIL sat_win_seen[%0d] got %b want 0000", i, seen); end
      n_cmp++; if (busy !== (i < 7)) begin n_err++; $display("FAIL sat_win_busy[%0d] got %b want %b", i, busy, (i < 7)); end
    end
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++; if (control !== 4'b0001) begin n_err++; $display("FAIL sat_clip[%0d] got %b want 0001", c, control); end
      do_strobe(seen);
      repeat (4) do_strobe(seen);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL sat_clip_end[%0d] busy got %b want 0", c, busy); end
    end
    repeat (4) step();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL sat_no_fourth got busy %b want 0", busy); end
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL sat_ovf_sticky got %b want 1", ovf); end
  endtask

  task automatic test_retarget();
    logic [3:0] seen;
    pulse(1'b1, 1'b0, 1'b0);
    step();
    n_cmp++; if (control !== 4'b0001) begin n_err++; $display("FAIL retarget_drop got %b want 0001", control); end
    pulse(1'b0, 1'b1, 1'b0);
    n_cmp++; if (control !== 4'b0001) begin n_err++; $display("FAIL retarget_hold got %b want 0001", control); end
    step();
    n_cmp++; if (control !== 4'b0010) begin n_err++; $display("FAIL retarget_expl got %b want 0010", control); end
    do_strobe(seen);
    n_cmp++; if (seen !== 4'b0010) begin n_err++; $display("FAIL retarget_seen got %b want 0010", seen); end
    repeat (6) do_strobe(seen);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL retarget_gap_busy got %b want 0", busy); end
    step();
    n_cmp++; if (control !== 4'b0001) begin n_err++; $display("FAIL retarget_drop_after got %b want 0001", control); end
    do_strobe(seen);
    repeat (4) do_strobe(seen);
    repeat (3) step();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL retarget_drained_busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_clip();
    logic [3:0] seen;
    pulse(1'b0, 1'b1, 1'b0);
    step();
    do_strobe(seen);
    repeat (2) do_strobe(seen);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_pre_busy got %b want 1", busy); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (control !== 4'b0000) begin n_err++; $display("FAIL rst_async_control got %b want 0000", control); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_async_busy got %b want 0", busy); end
    n_cmp++; if (cur_sfx !== 2'd0) begin n_err++; $display("FAIL rst_async_cur got %0d want 0", cur_sfx); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL rst_async_ovf got %b want 0", ovf); end
    step();
    reset_n = 1'b1;
    repeat (10) step();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_no_issue_busy got %b want 0", busy); end
    n_cmp++; if (control !== 4'b0000) begin n_err++; $display("FAIL rst_no_issue_ctrl got %b want 0000", control); end
    pulse(1'b0, 1'b0, 1'b1);
    step();
    n_cmp++; if (control !== 4'b0100) begin n_err++; $display("FAIL rst_new_event got %b want 0100", control); end
    n_cmp++; if (cur_sfx !== 2'd3) begin n_err++; $display("FAIL rst_new_cur got %0d want 3", cur_sfx); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_single_drop();
    test_simultaneous();
    test_issue_strobe_edge();
    test_preempt();
    test_saturation();
    test_retarget();
    test_reset_mid_clip();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
